// File: rtl/tf_add_scheduler_pkg.sv
// tf_add_scheduler_pkg
//   Shared definitions for the matrix-add scheduler slice: the FP32 word
//   width, the scheduler FSM state encoding and a helper that sizes the
//   element index counter.
//   Imported by tf_add_scheduler_if, tf_sched_fsm and tf_add_scheduler.
package tf_add_scheduler_pkg;

  localparam int FP_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  // A single-element matrix still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tf_add_scheduler_if.sv
// tf_add_scheduler_if
//   Handshake bus between the scheduler and one shared FP32 adder.
//   Signals:
//     add_load   scheduler -> adder  one-cycle pulse, operands valid
//     add_a      scheduler -> adder  operand 1 (FP32)
//     add_b      scheduler -> adder  operand 2 (FP32)
//     add_ready  adder -> scheduler  sum valid, held until acknowledged
//     add_result adder -> scheduler  sum (FP32)
//     add_ack    scheduler -> adder  acknowledges add_result
//   Modports: master (scheduler side), slave (adder side).
interface tf_add_scheduler_if;
  import tf_add_scheduler_pkg::*;

  logic            add_load;
  logic [FP_W-1:0] add_a;
  logic [FP_W-1:0] add_b;
  logic            add_ready;
  logic [FP_W-1:0] add_result;
  logic            add_ack;

  modport master (
    output add_load, add_a, add_b, add_ack,
    input  add_ready, add_result
  );

  modport slave (
    input  add_load, add_a, add_b, add_ack,
    output add_ready, add_result
  );

endinterface

// File: rtl/tf_add_scheduler_fsm.sv
// tf_sched_fsm
//   Control half of the matrix-add scheduler: state register, element index
//   counter and the adder handshake strobes.
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     start      in   run request, honoured only in IDLE and DONE
//     add_ready  in   adder result valid
//     timeout    in   WAIT has expired (tied low when the timeout is absent)
//     idx        out  element currently being processed
//     accept     out  start accepted this cycle (latch operands)
//     in_wait    out  waiting for the adder result
//     add_load   out  operand-valid pulse to the adder
//     add_ack    out  result acknowledge to the adder
//     ready      out  complete result matrix available
//     busy       out  a run is in progress
module tf_sched_fsm
  import tf_add_scheduler_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             add_ready,
  input  logic             timeout,
  output logic [IDX_W-1:0] idx,
  output logic             accept,
  output logic             in_wait,
  output logic             add_load,
  output logic             add_ack,
  output logic             ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  sched_state_t     state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // add_ready is only looked at in WAIT and ACK, so a stale or early
  // result never advances the sequence without a preceding load.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (add_ready) begin
          state_nxt = ST_ACK;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        // Hold the acknowledge until the adder drops its ready.
        if (!add_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    add_load = (state == ST_ISSUE);
    add_ack  = (state == ST_ACK);
    in_wait  = (state == ST_WAIT);
    ready    = (state == ST_DONE);
    busy     = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_ACK);
  end

endmodule

// File: rtl/tf_add_scheduler.sv
// tf_add_scheduler
//   Sequences one shared FP32 adder over a WIDTH x WIDTH matrix add C = A + B.
//   Both operand matrices are latched on start; element pairs are issued one
//   at a time in index order and each sum is stored in a result buffer.
//   Optional feature macro: TF_SCHED_TIMEOUT_EN (bounded wait on add_ready,
//   sticky error flag). Without it WAIT is unbounded and error is tied low.
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-low reset
//     start        in   run request (sampled in IDLE and DONE only)
//     A_flat       in   N FP32 elements, element k at [32k+31:32k]
//     B_flat       in   same packing as A_flat
//     result_flat  out  C[k] = A[k] + B[k], same packing
//     ready        out  result_flat holds a complete matrix
//     busy         out  run in progress
//     error        out  adder timeout flag
//     add_bus      master side of the adder handshake bus
module tf_add_scheduler
  import tf_add_scheduler_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [FP_W*WIDTH*WIDTH-1:0]   A_flat,
  input  logic [FP_W*WIDTH*WIDTH-1:0]   B_flat,
  output logic [FP_W*WIDTH*WIDTH-1:0]   result_flat,
  output logic                          ready,
  output logic                          busy,
  output logic                          error,
  tf_add_scheduler_if.master            add_bus
);

  localparam int N     = WIDTH * WIDTH;
  localparam int IDX_W = idx_width(N);

  logic [FP_W-1:0]  a_buf [N];
  logic [FP_W-1:0]  b_buf [N];
  logic [FP_W-1:0]  r_buf [N];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             in_wait;
  logic             capture;
  logic             timeout;
  logic             load_w;
  logic             ack_w;

  tf_sched_fsm #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .add_ready (add_bus.add_ready),
    .timeout   (timeout),
    .idx       (idx),
    .accept    (accept),
    .in_wait   (in_wait),
    .add_load  (load_w),
    .add_ack   (ack_w),
    .ready     (ready),
    .busy      (busy)
  );

  assign add_bus.add_load = load_w;
  assign add_bus.add_ack  = ack_w;
  assign capture          = in_wait && add_bus.add_ready;

  // Operands come from a private copy so the input buses may change freely
  // once a run has been accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        a_buf[k] <= '0;
        b_buf[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        a_buf[k] <= A_flat[k*FP_W +: FP_W];
        b_buf[k] <= B_flat[k*FP_W +: FP_W];
      end
    end
  end

  // Each sum lands in its own slot when the adder first reports ready.
  // Reset discards any partial matrix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        r_buf[k] <= '0;
      end
    end else if (capture) begin
      r_buf[idx] <= add_bus.add_result;
    end
  end

  // The operand mux follows idx, which is frozen from ISSUE through ACK,
  // so the operands stay put for the whole adder transaction.
  assign add_bus.add_a = a_buf[idx];
  assign add_bus.add_b = b_buf[idx];

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign result_flat[k*FP_W +: FP_W] = r_buf[k];
  end

`ifdef TF_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            error_q;

  // Counts consecutive WAIT cycles without a result; the final count fires
  // on the TIMEOUT-th such cycle.
  assign timeout = in_wait && !add_bus.add_ready && (wait_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (in_wait && !add_bus.add_ready && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky until the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_tf_add_scheduler.sv
// tb_tf_add_scheduler
//   Self-checking bench for tf_add_scheduler (WIDTH=2, TIMEOUT=16).
//   A behavioural adder with programmable latency and ready-hold answers the
//   handshake; a transaction-level model predicts busy/ready/strobes and the
//   result matrix. Timeout scenario is built only with TF_SCHED_TIMEOUT_EN.
module tb_tf_add_scheduler;
  import tf_add_scheduler_pkg::*;

  localparam int WIDTH   = 2;
  localparam int N       = WIDTH * WIDTH;
  localparam int TIMEOUT = 16;
  localparam int FW      = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [FW*N-1:0] A_flat = '0;
  logic [FW*N-1:0] B_flat = '0;
  logic [FW*N-1:0] result_flat;
  logic            ready, busy, error;

  tf_add_scheduler_if add_bus ();

  tf_add_scheduler #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A_flat      (A_flat),
    .B_flat      (B_flat),
    .result_flat (result_flat),
    .ready       (ready),
    .busy        (busy),
    .error       (error),
    .add_bus     (add_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat    = 3;
  int hold   = 0;
  bit mute   = 1'b0;
  int loads  = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // FP32 add via double precision: exact enough for binary32 round-to-nearest-even.
  function automatic logic [63:0] f2d(input logic [31:0] f);
    logic [10:0] e;
    e = 11'(f[30:23]) + 11'd896;
    return {f[31], e, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e;
    logic [30:0] keep;
    logic [28:0] rem;
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    e    = e - 11'd896;
    keep = {e[7:0], d[51:29]};
    rem  = d[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && keep[0])) keep = keep + 31'd1;
    return {d[63], keep};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    real x, y;
    x = $bitstoreal(f2d(a));
    y = $bitstoreal(f2d(b));
    return d2f($realtobits(x + y));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'b0, 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  function automatic logic [FW*N-1:0] rand_mat();
    logic [FW*N-1:0] m;
    for (int k = 0; k < N; k++) m[k*FW +: FW] = rand_fp();
    return m;
  endfunction

  // Behavioural adder: samples strobes mid-cycle, answers after lat edges,
  // keeps ready for hold extra acknowledged edges.
  initial begin
    logic        ld, ak;
    logic [31:0] oa, ob, res;
    int          cnt, hcnt;
    bit          pend;
    cnt = 0; hcnt = 0; pend = 1'b0; res = '0;
    add_bus.add_ready  = 1'b0;
    add_bus.add_result = '0;
    forever begin
      @(negedge clk);
      ld = add_bus.add_load;
      ak = add_bus.add_ack;
      oa = add_bus.add_a;
      ob = add_bus.add_b;
      @(posedge clk);
      #1;
      if (!reset) begin
        add_bus.add_ready = 1'b0;
        pend = 1'b0;
        hcnt = 0;
      end else begin
        if (add_bus.add_ready && ak) begin
          if (hcnt < hold) hcnt++;
          else begin
            add_bus.add_ready = 1'b0;
            hcnt = 0;
          end
        end
        if (ld) begin
          loads++;
          res  = fp_add(oa, ob);
          cnt  = lat;
          pend = !mute;
        end
        if (pend) begin
          if (cnt <= 1) begin
            add_bus.add_ready  = 1'b1;
            add_bus.add_result = res;
            pend = 1'b0;
          end else cnt--;
        end
      end
    end
  end

  // Transaction model: which phase of which element the run is in.
  bit              m_busy, m_ready, m_issue, m_wait, m_ack, m_err;
  int              m_k, m_wcnt;
  logic [31:0]     m_a [N];
  logic [31:0]     m_b [N];
  logic [FW*N-1:0] m_c;

  initial begin
    m_busy = 0; m_ready = 0; m_issue = 0; m_wait = 0; m_ack = 0; m_err = 0;
    m_k = 0; m_wcnt = 0; m_c = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_load", add_bus.add_load, 0);
        checkOutput("rst_ack", add_bus.add_ack, 0);
        checkOutput("rst_add_a", add_bus.add_a, 0);
        checkOutput("rst_add_b", add_bus.add_b, 0);
        checkOutput("rst_result", result_flat, 0);
        m_busy = 0; m_ready = 0; m_issue = 0; m_wait = 0; m_ack = 0; m_err = 0;
      end else begin
        checkOutput("busy", busy, 128'(m_busy));
        checkOutput("ready", ready, 128'(m_ready));
        checkOutput("add_load", add_bus.add_load, 128'(m_issue));
        checkOutput("add_ack", add_bus.add_ack, 128'(m_ack));
        checkOutput("error", error, 128'(m_err));
        if (m_issue) begin
          checkOutput($sformatf("add_a_e%0d", m_k), add_bus.add_a, 128'(m_a[m_k]));
          checkOutput($sformatf("add_b_e%0d", m_k), add_bus.add_b, 128'(m_b[m_k]));
        end
        if (m_ready) checkOutput("result_flat", result_flat, 128'(m_c));
        // Advance to what must hold after the coming edge.
        if (!m_busy) begin
          if (start) begin
            for (int k = 0; k < N; k++) begin
              m_a[k] = A_flat[k*FW +: FW];
              m_b[k] = B_flat[k*FW +: FW];
              m_c[k*FW +: FW] = fp_add(m_a[k], m_b[k]);
            end
            m_busy = 1; m_ready = 0; m_err = 0; m_issue = 1; m_k = 0;
          end
        end else if (m_issue) begin
          m_issue = 0; m_wait = 1; m_wcnt = 0;
        end else if (m_wait) begin
          if (add_bus.add_ready) begin
            m_wait = 0; m_ack = 1;
          end else begin
            m_wcnt++;
`ifdef TF_SCHED_TIMEOUT_EN
            if (m_wcnt == TIMEOUT) begin
              m_wait = 0; m_busy = 0; m_err = 1;
            end
`endif
          end
        end else if (m_ack) begin
          if (!add_bus.add_ready) begin
            m_ack = 0;
            if (m_k == N - 1) begin
              m_busy = 0; m_ready = 1;
            end else begin
              m_k++; m_issue = 1;
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [FW*N-1:0] a, input logic [FW*N-1:0] b);
    A_flat = a;
    B_flat = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitReady(input int budget, input string name);
    int n = 0;
    while (!ready && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_ready_in_budget"}, ready, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen, n;
    logic [FW*N-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    checkOutput("pin_add_5p84", fp_add(32'h40BAE148, 32'h40BAE148), 32'h413AE148);
    checkOutput("pin_add_one", fp_add(32'h3F800000, 32'h3F800000), 32'h40000000);
    checkOutput("pin_add_1_2", fp_add(32'h3F800000, 32'h40000000), 32'h40400000);
    checkOutput("pin_add_tie_even", fp_add(32'h3F800000, 32'h33800000), 32'h3F800000);

    // Uniform 5.84 matrix, latency 3.
    lat = 3; hold = 0; loads = 0;
    applyStimulus({N{32'h40BAE148}}, {N{32'h40BAE148}});
    waitReady(N * (3 + 3 + 1) + 4, "t1");
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("t1_c%0d", k), result_flat[k*FW +: FW], 32'h413AE148);
    checkOutput("t1_loads", loads, N);

    // Second start mid-run plus an input bus change must be ignored.
    loads = 0;
    applyStimulus({N{32'h3F800000}}, {N{32'h3F800000}});
    repeat (3) @(posedge clk);
    #1;
    A_flat = rand_mat();
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitReady(N * 8 + 4, "t2");
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("t2_c%0d", k), result_flat[k*FW +: FW], 32'h40000000);
    checkOutput("t2_loads", loads, N);

    // Adder keeps ready high five cycles after the acknowledge.
    hold = 5; loads = 0;
    applyStimulus(rand_mat(), rand_mat());
    waitReady(N * (3 + 5 + 4) + 4, "t3");
    checkOutput("t3_loads", loads, N);
    hold = 0;

    // Reset while waiting on element 2.
    applyStimulus(rand_mat(), rand_mat());
    seen = 0; n = 0;
    while (seen < 3 && n < 64) begin
      @(negedge clk);
      if (add_bus.add_load) seen++;
      n++;
    end
    checkOutput("t4_third_load_seen", 128'(seen), 3);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_ready", ready, 0);
    checkOutput("t4_load", add_bus.add_load, 0);
    checkOutput("t4_ack", add_bus.add_ack, 0);
    checkOutput("t4_add_a", add_bus.add_a, 0);
    checkOutput("t4_result", result_flat, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    loads = 0;
    applyStimulus(rand_mat(), rand_mat());
    waitReady(N * 8 + 4, "t4_rerun");
    checkOutput("t4_loads", loads, N);

    // Back-to-back runs with start held; second run takes the new buses.
    A_flat = rand_mat();
    B_flat = rand_mat();
    start  = 1'b1;
    @(posedge clk);
    #1;
    ra = rand_mat();
    rb = rand_mat();
    A_flat = ra;
    B_flat = rb;
    waitReady(N * 8 + 4, "t6_first");
    @(posedge clk);
    #1;
    checkOutput("t6_restart_busy", busy, 1);
    start = 1'b0;
    waitReady(N * 8 + 4, "t6_second");
    checkOutput("t6_c0", result_flat[FW-1:0], 128'(fp_add(ra[FW-1:0], rb[FW-1:0])));

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      lat  = $urandom_range(1, 5);
      hold = $urandom_range(0, 2);
      applyStimulus(rand_mat(), rand_mat());
      waitReady(N * (lat + hold + 4) + 4, $sformatf("rand%0d", r));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    hold = 0; lat = 3;

`ifdef TF_SCHED_TIMEOUT_EN
    // Adder never answers: error after TIMEOUT wait cycles, cleared by restart.
    mute = 1'b1;
    applyStimulus(rand_mat(), rand_mat());
    n = 0;
    while (!error && n < TIMEOUT + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t5_error", error, 1);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_ready", ready, 0);
    mute = 1'b0;
    applyStimulus(rand_mat(), rand_mat());
    checkOutput("t5_error_cleared", error, 0);
    waitReady(N * 8 + 4, "t5_rerun");
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
